// File: rtl/mult_wallace_pipe.sv
// Pipelined carry-save multiplier, unsigned or Baugh-Wooley signed.
// Define MULT_WALLACE_ACC_EN to add the acc_en port and accumulator.
module mult_wallace_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_b,
   input  logic               signed_mode,
`ifdef MULT_WALLACE_ACC_EN
   input  logic               acc_en,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result_final
);

   localparam int PW  = 2 * WIDTH;
   localparam int NR  = WIDTH + 1;
   localparam int NRG = (STAGES > 1) ? STAGES - 1 : 1;

   // Row r < WIDTH is a shifted partial product; row WIDTH is the
   // Baugh-Wooley correction constant (zero in unsigned mode).
   function automatic logic [PW-1:0] pp_row(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             sm,
      input int               r
   );
      logic [WIDTH-1:0] bs;
      logic [WIDTH-1:0] pp;
      logic [PW-1:0]    row;
      row = '0;
      if (r == WIDTH) begin
         if (sm)
            row = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
      end else begin
         bs = b >> r;
         pp = a & {WIDTH{bs[0]}};
         if (sm) begin
            if (r == WIDTH - 1)
               pp = pp ^ {1'b0, {(WIDTH-1){1'b1}}};
            else
               pp = pp ^ {1'b1, {(WIDTH-1){1'b0}}};
         end
         row = PW'(pp) << r;
      end
      return row;
   endfunction

   logic             stall;
   logic [WIDTH-1:0] a_q [NRG];
   logic [WIDTH-1:0] b_q [NRG];
   logic             m_q [NRG];
   logic [PW-1:0]    s_q [NRG];
   logic [PW-1:0]    c_q [NRG];
   logic [NRG-1:0]   v_q;

   logic [WIDTH-1:0] a_x [STAGES];
   logic [WIDTH-1:0] b_x [STAGES];
   logic             m_x [STAGES];
   logic             v_x [STAGES];
   logic [PW-1:0]    s_x [STAGES];
   logic [PW-1:0]    c_x [STAGES];
   logic [PW-1:0]    s_n [STAGES];
   logic [PW-1:0]    c_n [STAGES];

   logic [PW-1:0]    sum;
   logic [PW-1:0]    car;
   logic [PW-1:0]    row;
   logic [PW-1:0]    tmp;
   logic [PW-1:0]    prod;
   logic [PW-1:0]    res_n;

`ifdef MULT_WALLACE_ACC_EN
   logic             e_q [NRG];
   logic             e_x [STAGES];
   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    base;
`endif

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   // Per-stage carry-save reduction of its share of rows, then final add.
   always_comb begin
      sum    = '0;
      car    = '0;
      row    = '0;
      tmp    = '0;
      a_x[0] = operand_a;
      b_x[0] = operand_b;
      m_x[0] = signed_mode;
      v_x[0] = in_valid;
      s_x[0] = '0;
      c_x[0] = '0;
`ifdef MULT_WALLACE_ACC_EN
      e_x[0] = acc_en;
`endif
      for (int s = 1; s < STAGES; s++) begin
         a_x[s] = a_q[s-1];
         b_x[s] = b_q[s-1];
         m_x[s] = m_q[s-1];
         v_x[s] = v_q[s-1];
         s_x[s] = s_q[s-1];
         c_x[s] = c_q[s-1];
`ifdef MULT_WALLACE_ACC_EN
         e_x[s] = e_q[s-1];
`endif
      end
      for (int s = 0; s < STAGES; s++) begin
         sum = s_x[s];
         car = c_x[s];
         for (int r = 0; r < NR; r++) begin
            if (r >= (s * NR) / STAGES &&
                r < ((s + 1) * NR) / STAGES) begin
               row = pp_row(a_x[s], b_x[s], m_x[s], r);
               tmp = sum ^ car ^ row;
               car = ((sum & car) | (sum & row) | (car & row)) << 1;
               sum = tmp;
            end
         end
         s_n[s] = sum;
         c_n[s] = car;
      end
      prod  = s_n[STAGES-1] + c_n[STAGES-1];
      res_n = prod;
`ifdef MULT_WALLACE_ACC_EN
      base = (out_valid && out_ready) ? result_final : acc_q;
      if (e_x[STAGES-1])
         res_n = base + prod;
`endif
   end

   // Valid bits and result advance together unless the output stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q          <= '0;
         out_valid    <= 1'b0;
         result_final <= '0;
      end else if (!stall) begin
         for (int s = 0; s < NRG; s++)
            v_q[s] <= v_x[s];
         out_valid <= v_x[STAGES-1];
         if (v_x[STAGES-1])
            result_final <= res_n;
      end
   end

   // Intermediate datapath registers; no reset needed.
   always_ff @(posedge clk) begin
      if (!stall) begin
         for (int s = 0; s < NRG; s++) begin
            a_q[s] <= a_x[s];
            b_q[s] <= b_x[s];
            m_q[s] <= m_x[s];
            s_q[s] <= s_n[s];
            c_q[s] <= c_n[s];
`ifdef MULT_WALLACE_ACC_EN
            e_q[s] <= e_x[s];
`endif
         end
      end
   end

`ifdef MULT_WALLACE_ACC_EN
   // Accumulator follows each delivered result.
   always_ff @(posedge clk) begin
      if (rst)
         acc_q <= '0;
      else if (out_valid && out_ready)
         acc_q <= result_final;
   end
`endif

endmodule

// File: tb/tb_mult_wallace_pipe.sv
// Bench for mult_wallace_pipe (WIDTH=8, STAGES=2).
// Define MULT_WALLACE_ACC_EN to also exercise the accumulator.
module tb_mult_wallace_pipe;

   localparam int W  = 8;
   localparam int S  = 2;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  operand_a = '0;
   logic [W-1:0]  operand_b = '0;
   logic          signed_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [PW-1:0] result_final;
`ifdef MULT_WALLACE_ACC_EN
   logic          acc_en = 1'b0;
`endif

   mult_wallace_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .operand_a(operand_a),
      .operand_b(operand_b),
      .signed_mode(signed_mode),
`ifdef MULT_WALLACE_ACC_EN
      .acc_en(acc_en),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result_final(result_final)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] got_q[$];
   int            got_c[$];
   logic [PW-1:0] acc_m = '0;
   logic [PW-1:0] p;

   function automatic logic [PW-1:0] ref_mul(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic         m
   );
      longint x, y;
      if (m) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'(a);
         y = longint'(b);
      end
      return PW'(x * y);
   endfunction

   always @(posedge clk) cyc++;

   // Reference model: expected results in acceptance order.
   always @(negedge clk) begin
      if (rst) begin
         acc_m = '0;
      end else begin
         if (in_valid && in_ready) begin
            p = ref_mul(operand_a, operand_b, signed_mode);
`ifdef MULT_WALLACE_ACC_EN
            if (acc_en)
               p = p + acc_m;
            acc_m = p;
`endif
            exp_q.push_back(p);
         end
         if (out_valid && out_ready) begin
            got_q.push_back(result_final);
            got_c.push_back(cyc);
         end
      end
   end

   task automatic clear_q();
      exp_q.delete();
      got_q.delete();
      got_c.delete();
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (got_q.size() < exp_q.size() && k < 300) begin
         @(negedge clk); #1;
         k++;
      end
      repeat (S + 2) @(negedge clk);
      #1;
   endtask

   task automatic drive_rand();
      operand_a   = W'($urandom);
      operand_b   = W'($urandom);
      signed_mode = 1'($urandom);
`ifdef MULT_WALLACE_ACC_EN
      acc_en      = 1'($urandom);
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
      end
      n_cmp++;
      if (result_final !== '0) begin
         n_bad++; $display("FAIL reset_result got=%h want=0", result_final);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
      end
      clear_q();
   endtask

   task automatic test_corner();
      logic [W-1:0]  ta[4] = '{8'hFF, 8'h80, 8'h80, 8'h80};
      logic [W-1:0]  tb[4] = '{8'hFF, 8'h80, 8'h7F, 8'h7F};
      logic          tm[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [PW-1:0] te[4] = '{16'hFE01, 16'h4000, 16'hC080, 16'h3F80};
      int lat;
      bit seen;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; operand_a = ta[i]; operand_b = tb[i];
         signed_mode = tm[i];
`ifdef MULT_WALLACE_ACC_EN
         acc_en = 1'b0;
`endif
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 1; seen = 0;
         for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            else begin
               @(posedge clk); lat++;
            end
         end
         n_cmp++;
         if (!seen || lat != S) begin
            n_bad++;
            $display("FAIL corner%0d_latency got=%0d seen=%0b want=%0d",
                     i, lat, seen, S);
         end
         n_cmp++;
         if (result_final !== te[i]) begin
            n_bad++;
            $display("FAIL corner%0d_value got=%h want=%h",
                     i, result_final, te[i]);
         end
      end
      repeat (2) @(posedge clk);
      clear_q();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         drive_rand();
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain();
      n_cmp++;
      if (got_q.size() != 10 || exp_q.size() != 10) begin
         n_bad++;
         $display("FAIL b2b_count got=%0d accepted=%0d want=10",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL b2b_value%0d got=%h want=%h",
                     i, got_q[i], exp_q[i]);
         end
         n_cmp++;
         if (got_c[i] - got_c[0] != i) begin
            n_bad++;
            $display("FAIL b2b_gap%0d got=%0d want=%0d",
                     i, got_c[i] - got_c[0], i);
         end
      end
      clear_q();
   endtask

   task automatic test_stall();
      logic [PW-1:0] held;
      bit seen;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         drive_rand();
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      held = result_final;
      n_cmp++;
      if (!seen || exp_q.size() == 0 || held !== exp_q[0]) begin
         n_bad++;
         $display("FAIL stall_first got=%h seen=%0b want=%h", held, seen,
                  (exp_q.size() > 0) ? exp_q[0] : '0);
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
             result_final !== held) begin
            n_bad++;
            $display("FAIL stall_hold%0d rdy=%b vld=%b res=%h want 0/1/%h",
                     i, in_ready, out_valid, result_final, held);
         end
         @(posedge clk); #1;
         in_valid = 1'b1;
         drive_rand();
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      n_cmp++;
      if (got_q.size() != 2 || exp_q.size() != 2) begin
         n_bad++;
         $display("FAIL stall_count got=%0d accepted=%0d want=2",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL stall_value%0d got=%h want=%h",
                     i, got_q[i], exp_q[i]);
         end
      end
      clear_q();
   endtask

   task automatic test_reset_mid();
      int bad;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         drive_rand();
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || result_final !== '0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_state vld=%b res=%h rdy=%b want 0/0/1",
                  out_valid, result_final, in_ready);
      end
      clear_q();
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0 || got_q.size() != 0) begin
         n_bad++;
         $display("FAIL rstmid_stale got=%0d valid cycles, %0d results want=0",
                  bad, got_q.size());
      end
      clear_q();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         drive_rand();
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      n_cmp++;
      if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL rand_count got=%0d want=%0d",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL rand_value%0d got=%h want=%h",
                     i, got_q[i], exp_q[i]);
         end
      end
      clear_q();
   endtask

`ifdef MULT_WALLACE_ACC_EN
   task automatic test_acc();
      logic [W-1:0]  ta[3] = '{8'd3, 8'd5, 8'hFF};
      logic [W-1:0]  tb[3] = '{8'd4, 8'd6, 8'hFF};
      logic          te_n[3] = '{1'b0, 1'b1, 1'b1};
      logic [PW-1:0] te[3] = '{16'd12, 16'd42, 16'hFE2B};
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      clear_q();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; operand_a = ta[i]; operand_b = tb[i];
         signed_mode = 1'b0; acc_en = te_n[i];
      end
      @(posedge clk); #1;
      in_valid = 1'b0; acc_en = 1'b0;
      wait_drain();
      n_cmp++;
      if (got_q.size() != 3) begin
         n_bad++;
         $display("FAIL acc_count got=%0d want=3", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         n_cmp++;
         if (got_q[i] !== te[i]) begin
            n_bad++;
            $display("FAIL acc_value%0d got=%h want=%h", i, got_q[i], te[i]);
         end
      end
      clear_q();
   endtask
`endif

   initial begin
      test_reset();
      test_corner();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_random();
`ifdef MULT_WALLACE_ACC_EN
      test_acc();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_wallace_pipe.md
MULT_WALLACE_PIPE -- requirements
Module: mult_wallace_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 4..32).
REQ-002 The module SHALL have parameter STAGES, default 2, meaning register stages from input capture to result (legal range 1..4).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The module SHALL have ports operand_a and operand_b, each an input of WIDTH bits: the multiplicand and the multiplier.
REQ-008 The module SHALL have port signed_mode, input, 1 bit, sampled with the beat: 1 selects two's-complement, 0 selects unsigned.
REQ-009 The module SHALL have port out_valid, output, 1 bit: result_final holds a valid product.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 The module SHALL have port result_final, output, 2*WIDTH bits: the product.

Function
REQ-012 The block SHALL accept a beat on every cycle where in_valid && in_ready; it SHALL deliver a beat on every cycle where out_valid && out_ready.
REQ-013 The block SHALL compute the exact 2*WIDTH-bit product with no truncation in both modes, using partial-product generation and carry-save reduction (signed: Baugh-Wooley complemented MSB partial products plus correction constants).
REQ-014 The reduction tree SHALL be split across STAGES register boundaries; latency from acceptance to out_valid SHALL be exactly STAGES cycles when not stalled.
REQ-015 The pipeline SHALL use a global stall: stall = out_valid && !out_ready; while stalled, every stage register, its valid bit and result_final SHALL hold.
REQ-016 in_ready SHALL equal !stall, combinationally.
REQ-017 Throughput SHALL be one beat per cycle while out_ready is held at 1.
REQ-018 Each stage SHALL carry a valid bit; a bubble (no beat accepted) SHALL advance as an invalid slot when not stalled.
REQ-019 signed_mode SHALL travel with its beat; mixing modes on consecutive beats SHALL produce a correct product for each beat.
REQ-020 result_final SHALL be held stable, unchanged, while out_valid && !out_ready.
REQ-021 The result order SHALL equal the acceptance order; no beat SHALL be dropped or duplicated.

Reset
REQ-022 On rst=1 at a clock edge, all valid bits SHALL clear, out_valid SHALL be 0, and result_final SHALL be 0.
REQ-023 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-024 Datapath registers other than result_final need not be reset.

Configuration
REQ-025 With macro MULT_WALLACE_ACC_EN defined, the block SHALL add input acc_en (1 bit, sampled with the beat) and an internal 2*WIDTH-bit accumulator.
REQ-026 With MULT_WALLACE_ACC_EN defined and acc_en=1, the delivered result_final SHALL be accumulator + product, modulo 2^(2*WIDTH).
REQ-027 With MULT_WALLACE_ACC_EN defined and acc_en=0, the delivered result SHALL be the plain product, and the accumulator SHALL be loaded with that product.
REQ-028 With MULT_WALLACE_ACC_EN defined, the accumulator SHALL update only on output handshake and SHALL reset to 0.
REQ-029 Without MULT_WALLACE_ACC_EN, the acc_en port and the accumulator SHALL be absent and the behaviour SHALL be pure multiply.

Verification
REQ-030 The bench SHALL cover: WIDTH=8, STAGES=2, unsigned, 0xFF*0xFF -> result_final=0xFE01 exactly 2 cycles after acceptance.
REQ-031 The bench SHALL cover: signed, 0x80*0x80 -> 0x4000; signed 0x80*0x7F -> 0xC080; unsigned 0x80*0x7F -> 0x3F80.
REQ-032 The bench SHALL cover: 10 back-to-back beats with out_ready=1 -> 10 results on consecutive cycles, in order.
REQ-033 The bench SHALL cover: out_ready=0 for 5 cycles with a result pending -> in_ready=0, result_final and out_valid held; on release, no loss and no duplicate.
REQ-034 The bench SHALL cover: rst pulsed with 2 beats in flight -> out_valid=0, result_final=0 next cycle, no stale result later.
REQ-035 The bench SHALL cover: MULT_WALLACE_ACC_EN defined, beats (3*4, acc_en=0), (5*6, acc_en=1), (0xFF*0xFF, acc_en=1), unsigned -> results 12, 42, 0xFE2B.
